// File: rtl/branch_ctrl.sv
// Branch sequencing controller: 2-bit BHT prediction in ID, resolution in EX,
// PC redirect / pipeline flush generation and branch performance counters.
module branch_ctrl #(
    parameter int XLEN    = 32,
    parameter int BHT_IDX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            id_valid,
    input  logic            id_branch,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_target,
    output logic            id_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_pred_taken,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if,
    output logic            flush_id,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispredict_cnt
);

    localparam int BHT_N = 1 << BHT_IDX;

    logic [1:0]         bht [BHT_N];
    logic [BHT_IDX-1:0] id_idx;
    logic [BHT_IDX-1:0] ex_idx;
    logic [1:0]         ex_ctr;
    logic [1:0]         ex_ctr_nxt;
    logic               id_pred_raw;
    logic               ex_resolve;
    logic               ex_mispredict;
    logic [31:0]        branch_cnt_q;
    logic [31:0]        mispredict_cnt_q;

    // PC bits outside the word-aligned BHT index are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{id_pc[XLEN-1:BHT_IDX+2], id_pc[1:0]};

    assign id_idx = id_pc[BHT_IDX+1:2];
    assign ex_idx = ex_pc[BHT_IDX+1:2];

    assign id_pred_raw   = id_valid & id_branch & bht[id_idx][1];
    assign ex_resolve    = !stall & ex_valid & ex_branch;
    assign ex_mispredict = ex_resolve & (ex_taken != ex_pred_taken);

    // Saturating 2-bit counter step for the resolving entry.
    always_comb begin
        ex_ctr     = bht[ex_idx];
        ex_ctr_nxt = ex_ctr;
        if (ex_taken) begin
            if (ex_ctr != 2'b11) ex_ctr_nxt = ex_ctr + 2'b01;
        end else begin
            if (ex_ctr != 2'b00) ex_ctr_nxt = ex_ctr - 2'b01;
        end
    end

    // EX mispredict outranks an ID predict-taken: the ID instruction is wrong-path.
    always_comb begin
        id_pred_taken = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        flush_if      = 1'b0;
        flush_id      = 1'b0;
        if (!rst) begin
            id_pred_taken = id_pred_raw;
            if (ex_mispredict) begin
                redirect    = 1'b1;
                flush_if    = 1'b1;
                flush_id    = 1'b1;
                redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
            end else if (!stall && id_pred_raw) begin
                redirect    = 1'b1;
                flush_if    = 1'b1;
                redirect_pc = id_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= 2'b01;
            end
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (ex_resolve) begin
            bht[ex_idx]  <= ex_ctr_nxt;
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (ex_mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: driver pushes hand-computed expectations,
// a negedge monitor pops and compares the combinational/registered outputs.
module tb_branch_ctrl;

  localparam int W = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        id_valid;
  logic        id_branch;
  logic [31:0] id_pc;
  logic [31:0] id_target;
  logic        id_pred_taken;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_pred_taken;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if;
  logic        flush_id;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  logic [W-1:0] exp_q[$];
  int           chk_cnt  = 0;
  int           pass_cnt = 0;
  int           cyc_no   = 0;

  branch_ctrl #(.XLEN(32), .BHT_IDX(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_branch      (id_branch),
    .id_pc          (id_pc),
    .id_target      (id_target),
    .id_pred_taken  (id_pred_taken),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_pred_taken  (ex_pred_taken),
    .ex_taken       (ex_taken),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp(input logic pred, input logic redir,
                                       input logic [31:0] rpc, input logic fif,
                                       input logic fid, input logic [31:0] b,
                                       input logic [31:0] m);
    return {pred, redir, fif, fid, rpc, b, m};
  endfunction

  // driver: inputs change #1 after posedge, checked at the following negedge
  task automatic drive(input bit chk, input logic r, input logic s,
                       input logic iv, input logic ib,
                       input logic [31:0] ipc, input logic [31:0] itg,
                       input logic ev, input logic eb, input logic ep,
                       input logic et, input logic [31:0] epc,
                       input logic [31:0] etg, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    rst = r; stall = s;
    id_valid = iv; id_branch = ib; id_pc = ipc; id_target = itg;
    ex_valid = ev; ex_branch = eb; ex_pred_taken = ep; ex_taken = et;
    ex_pc = epc; ex_target = etg;
    cyc_no++;
    if (chk) exp_q.push_back(e);
  endtask

  // scoreboard monitor
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {id_pred_taken, redirect, flush_if, flush_id, redirect_pc,
                 branch_cnt, mispredict_cnt};
      chk_cnt++;
      if (mon_got === mon_exp) pass_cnt++;
      else $display("FAIL cyc%0d pred/redir/fif/fid/rpc/bcnt/mcnt got=%h exp=%h",
                    cyc_no, mon_got, mon_exp);
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0;
    id_valid = 0; id_branch = 0; id_pc = 0; id_target = 0;
    ex_valid = 0; ex_branch = 0; ex_pred_taken = 0; ex_taken = 0;
    ex_pc = 0; ex_target = 0;

    //    chk rst stl iv ib id_pc         id_tgt        ev eb ep et ex_pc         ex_tgt
    drive(0, 1, 0,  0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,   '0);
    // reset forces outputs low even with an EX mispredict present
    drive(1, 1, 0,  1, 1, 32'h100,      32'h80,       1, 1, 0, 1, 32'h100,      32'h80,
          exp(0, 0, 32'h0, 0, 0, 0, 0));
    drive(1, 0, 0,  1, 1, 32'h100,      32'h80,       0, 0, 0, 0, 32'h0,        32'h0,
          exp(0, 0, 32'h0, 0, 0, 0, 0));
    // first resolution: taken vs predicted not-taken
    drive(1, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 0, 1, 32'h100,      32'h80,
          exp(0, 1, 32'h80, 1, 1, 0, 0));
    drive(1, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 1, 1, 32'h100,      32'h80,
          exp(0, 0, 32'h0, 0, 0, 1, 1));
    drive(1, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 1, 1, 32'h100,      32'h80,
          exp(0, 0, 32'h0, 0, 0, 2, 1));
    // entry 0 saturated at 11: ID predict-taken redirect, one bubble
    drive(1, 0, 0,  1, 1, 32'h100,      32'h80,       0, 0, 0, 0, 32'h0,        32'h0,
          exp(1, 1, 32'h80, 1, 0, 3, 1));
    // predicted-taken resolves not-taken at 0x200 (same entry 0) -> 11 to 10
    drive(1, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 1, 0, 32'h200,      32'h300,
          exp(0, 1, 32'h204, 1, 1, 3, 1));
    // same-index read and update: ID sees old 10 while entry drops to 01
    drive(1, 0, 0,  1, 1, 32'h100,      32'h80,       1, 1, 0, 0, 32'h200,      32'h300,
          exp(1, 1, 32'h80, 1, 0, 4, 2));
    drive(1, 0, 0,  1, 1, 32'h100,      32'h80,       1, 1, 0, 0, 32'h200,      32'h300,
          exp(0, 0, 32'h0, 0, 0, 5, 2));
    // not-taken from 00 holds at 00
    drive(1, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 0, 0, 32'h200,      32'h300,
          exp(0, 0, 32'h0, 0, 0, 6, 2));
    drive(1, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 0, 1, 32'h200,      32'h300,
          exp(0, 1, 32'h300, 1, 1, 7, 2));
    drive(1, 0, 0,  1, 1, 32'h100,      32'h80,       0, 0, 0, 0, 32'h0,        32'h0,
          exp(0, 0, 32'h0, 0, 0, 8, 3));
    // train entry 1 up to 11
    drive(1, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 0, 1, 32'h104,      32'h10,
          exp(0, 1, 32'h10, 1, 1, 8, 3));
    drive(1, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 0, 1, 32'h104,      32'h10,
          exp(0, 1, 32'h10, 1, 1, 9, 4));
    // EX mispredict (0x400) beats ID predict-taken (0x500)
    drive(1, 0, 0,  1, 1, 32'h104,      32'h500,      1, 1, 0, 1, 32'h104,      32'h400,
          exp(1, 1, 32'h400, 1, 1, 10, 5));
    // stall suppresses redirect/update; prediction stays visible
    drive(1, 0, 1,  1, 1, 32'h104,      32'h500,      1, 1, 1, 0, 32'h104,      32'h400,
          exp(1, 0, 32'h0, 0, 0, 11, 6));
    drive(1, 0, 1,  1, 1, 32'h104,      32'h500,      1, 1, 1, 0, 32'h104,      32'h400,
          exp(1, 0, 32'h0, 0, 0, 11, 6));
    drive(1, 0, 0,  1, 1, 32'h104,      32'h500,      1, 1, 1, 0, 32'h104,      32'h400,
          exp(1, 1, 32'h108, 1, 1, 11, 6));
    // EX slot drained; entry 1 now 10, still predicts taken
    drive(1, 0, 0,  1, 1, 32'h104,      32'h500,      0, 0, 0, 0, 32'h0,        32'h0,
          exp(1, 1, 32'h500, 1, 0, 12, 7));
    // mid-run reset with EX mispredict present
    drive(1, 1, 0,  1, 1, 32'h104,      32'h500,      1, 1, 0, 1, 32'h104,      32'h400,
          exp(0, 0, 32'h0, 0, 0, 12, 7));
    // after reset: entries weakly not-taken, counters cleared, non-branch ignored
    drive(1, 0, 0,  1, 1, 32'h104,      32'h500,      1, 0, 0, 1, 32'h104,      32'h400,
          exp(0, 0, 32'h0, 0, 0, 0, 0));
    drive(1, 0, 0,  1, 1, 32'h100,      32'h80,       1, 0, 0, 1, 32'h104,      32'h400,
          exp(0, 0, 32'h0, 0, 0, 0, 0));
    // ex_pc + 4 wraps modulo 2^32
    drive(1, 0, 0,  0, 0, 32'h0,        32'h0,        1, 1, 1, 0, 32'hFFFF_FFFC, 32'h40,
          exp(0, 1, 32'h0, 1, 1, 0, 0));
    drive(1, 0, 0,  0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        32'h0,
          exp(0, 0, 32'h0, 0, 0, 1, 1));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
